// File: rtl/audio_out_fifo_if.sv
// audio_out_fifo_if: filter-side sample strobe and codec-side write port of the audio output FIFO.
// OVF_COUNT_EN adds the ovf_count dropped-sample counter to the bundle.
interface audio_out_fifo_if #(
   parameter int WIDTH = 24
);
   logic [WIDTH-1:0] in_sample;
   logic             in_valid;
   logic             write_ready;
   logic             write;
   logic [WIDTH-1:0] writedata_left;
   logic [WIDTH-1:0] writedata_right;
   logic             empty;
   logic             full;
   logic             overflow;
`ifdef OVF_COUNT_EN
   logic [15:0]      ovf_count;
   modport master (output in_sample, in_valid, write_ready,
                   input  write, writedata_left, writedata_right, empty, full, overflow, ovf_count);
   modport slave  (input  in_sample, in_valid, write_ready,
                   output write, writedata_left, writedata_right, empty, full, overflow, ovf_count);
`else
   modport master (output in_sample, in_valid, write_ready,
                   input  write, writedata_left, writedata_right, empty, full, overflow);
   modport slave  (input  in_sample, in_valid, write_ready,
                   output write, writedata_left, writedata_right, empty, full, overflow);
`endif
endinterface

// File: rtl/audio_out_fifo.sv
// audio_out_fifo: buffers mono FIR samples and writes each to both codec channels.
// OVF_COUNT_EN adds a saturating 16-bit count of dropped samples.
module audio_out_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input logic              i_clock_50,
   input logic              i_reset,
   audio_out_fifo_if.slave  bus
);
   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_LOAD = 2'd1;
   localparam logic [1:0]  S_WAIT = 2'd2;
   localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [1:0]       r_state;
   logic             r_write;
   logic [WIDTH-1:0] r_data;
   logic             r_overflow;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_state_nxt;

   // A full FIFO rejects pushes even when a pop happens in the same cycle.
   assign w_push = bus.in_valid && (r_count != FULL);
   assign w_pop  = (r_state == S_LOAD);

   always_comb begin
      w_state_nxt = (r_state == S_IDLE) ? ((r_count != '0) ? S_LOAD : S_IDLE) :
                    (r_state == S_LOAD) ? S_WAIT :
                    (r_state == S_WAIT) ? (bus.write_ready ? S_IDLE : S_WAIT) : S_IDLE;
   end

   always_ff @(posedge i_clock_50) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.in_sample;
   end

   always_ff @(posedge i_clock_50) begin
      if (!i_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_state    <= S_IDLE;
         r_write    <= 1'b0;
         r_data     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_write <= (r_state == S_WAIT) && bus.write_ready;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_data   <= r_mem[r_rd_ptr];
         end
         if (bus.in_valid && !w_push) r_overflow <= 1'b1;
      end
   end

`ifdef OVF_COUNT_EN
   logic [15:0] r_ovf_count;
   always_ff @(posedge i_clock_50) begin
      if (!i_reset) r_ovf_count <= '0;
      else if (bus.in_valid && !w_push && r_ovf_count != 16'hFFFF) r_ovf_count <= r_ovf_count + 16'd1;
   end
   assign bus.ovf_count = r_ovf_count;
`endif

   assign bus.write           = r_write;
   assign bus.writedata_left  = r_data;
   assign bus.writedata_right = r_data;
   assign bus.empty           = (r_count == '0);
   assign bus.full            = (r_count == FULL);
   assign bus.overflow        = r_overflow;
endmodule
